// File: rtl/pix_stream_in.sv
// Pixel ingress: SOF-aligned valid/ready stream into a FIFO popped by pix_req.
// Define PIX_STREAM_IN_PATTERN_EN to add the pattern_en colour-bar generator.
module pix_stream_in #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [23:0]              s_data,
  input  logic                     s_valid,
  input  logic                     s_sof,
  output logic                     s_ready,
  input  logic                     pix_req,
  output logic [23:0]              pix_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow,
  output logic                     sof_err,
  output logic                     frame_done,
`ifdef PIX_STREAM_IN_PATTERN_EN
  input  logic                     pattern_en,
`endif
  input  logic                     clr
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int FRAME = WIDTH * HEIGHT;
  localparam int CW    = $clog2(FRAME + 1);

  typedef enum logic {
    WAIT_SOF,
    STREAM
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_nx;
  logic [AW-1:0]   wr_q, rd_q;
  logic [LW-1:0]   count_q, count_d;
  logic [23:0]     mem_q [DEPTH];
  logic [23:0]     pix_q, pix_d;
  logic            uf_q;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            full, empty;
  logic            accept, wr_en, last;
  logic            pat_on, rd_req, rd_en, uf_set;
  logic [23:0]     bar_rgb;

  assign full    = count_q == LW'(DEPTH);
  assign empty   = count_q == '0;
  // Gated by rst so s_ready drops the instant reset asserts.
  assign s_ready = rst & ~full;
  assign accept  = s_valid & s_ready;
  assign wr_en   = accept & (s_sof | (state_q == STREAM));
  assign cnt_nx  = s_sof ? CW'(1) : cnt_q + CW'(1);
  assign last    = wr_en & (cnt_nx == CW'(FRAME));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= WAIT_SOF;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_SOF: if (wr_en) state_d = last ? WAIT_SOF : STREAM;
      STREAM:   if (last)  state_d = WAIT_SOF;
      default:  state_d = WAIT_SOF;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    err_d  = accept & s_sof & (state_q == STREAM);
    if (wr_en) begin
      cnt_d  = last ? '0 : cnt_nx;
      done_d = last;
    end
  end

`ifdef PIX_STREAM_IN_PATTERN_EN
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [XW-1:0] col_q;
  logic [2:0]    bar_idx;

  assign pat_on  = pattern_en;
  assign bar_idx = 3'((32'(col_q) * 8) / WIDTH);

  always_comb begin
    bar_rgb = 24'h000000;
    unique case (bar_idx)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      3'd7: bar_rgb = 24'h000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
    end else if (pattern_en && pix_req) begin
      col_q <= (col_q == XW'(WIDTH - 1)) ? '0 : col_q + XW'(1);
    end
  end
`else
  assign pat_on  = 1'b0;
  assign bar_rgb = 24'h000000;
`endif

  assign rd_req = pix_req & ~pat_on;
  assign rd_en  = rd_req & ~empty;
  assign uf_set = rd_req & empty;

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    pix_d = pix_q;
    unique case (1'b1)
      rd_en:              pix_d = mem_q[rd_q];
      uf_set:             pix_d = 24'h000000;
      (pat_on & pix_req): pix_d = bar_rgb;
      default:            pix_d = pix_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      pix_q   <= '0;
      uf_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      count_q <= count_d;
      pix_q   <= pix_d;
      err_q   <= err_d;
      done_q  <= done_d;
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (rd_en) rd_q <= rd_q + AW'(1);
      // Set beats clear when both happen together.
      if (uf_set)   uf_q <= 1'b1;
      else if (clr) uf_q <= 1'b0;
    end
  end

  assign pix_data   = pix_q;
  assign level      = count_q;
  assign underflow  = uf_q;
  assign sof_err    = err_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_pix_stream_in.sv
// Directed self-checking bench for pix_stream_in (WIDTH=4, HEIGHT=2, DEPTH=16).
module tb_pix_stream_in;
  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic        pix_req = 1'b0;
  logic        clr = 1'b0;
  logic        s_ready;
  logic [23:0] pix_data;
  logic [4:0]  level;
  logic        underflow;
  logic        sof_err;
  logic        frame_done;
`ifdef PIX_STREAM_IN_PATTERN_EN
  logic        pattern_en = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  pix_stream_in #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_sof      (s_sof),
    .s_ready    (s_ready),
    .pix_req    (pix_req),
    .pix_data   (pix_data),
    .level      (level),
    .underflow  (underflow),
    .sof_err    (sof_err),
    .frame_done (frame_done),
`ifdef PIX_STREAM_IN_PATTERN_EN
    .pattern_en (pattern_en),
`endif
    .clr        (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [23:0] d, input logic sof);
    s_data  = d;
    s_sof   = sof;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic pop;
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int fd;
    int ef;

    #2;
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_pix", 32'(pix_data), 0);
    chk("rst_uf", 32'(underflow), 0);
    chk("rst_err", 32'(sof_err), 0);
    chk("rst_done", 32'(frame_done), 0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rel_ready", 32'(s_ready), 1);

    for (int i = 0; i < 3; i++) begin
      beat(24'(32'h10 + i), 1'b0);
      chk("align_drop", 32'(level), 0);
    end
    beat(24'h112233, 1'b1);
    chk("align_level", 32'(level), 1);
    pop();
    chk("align_pix", 32'(pix_data), 'h112233);
    chk("align_empty", 32'(level), 0);

    do_reset();
    fd = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data  = 24'(32'hA0 + i);
      s_sof   = (i == 0);
      pix_req = (i > 0);
      tick();
      fd += 32'(frame_done);
      chk("frame_done", 32'(frame_done), 32'(i == 7));
      if (i > 0) chk("frame_pix", 32'(pix_data), 32'('hA0 + i - 1));
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    tick();
    pix_req = 1'b0;
    chk("frame_last", 32'(pix_data), 'hA7);
    chk("frame_cnt", 32'(fd), 1);
    chk("frame_lvl", 32'(level), 0);
    chk("frame_uf", 32'(underflow), 0);
    beat(24'hEE, 1'b0);
    chk("post_drop", 32'(level), 0);
    chk("post_done", 32'(frame_done), 0);

    do_reset();
    for (int i = 0; i < 16; i++) beat(24'(32'h300 + i), (i % 8) == 0);
    chk("bp_level", 32'(level), 16);
    chk("bp_ready", 32'(s_ready), 0);
    beat(24'hBAD, 1'b1);
    chk("bp_reject", 32'(level), 16);
    pop();
    chk("bp_pix0", 32'(pix_data), 'h300);
    chk("bp_ready1", 32'(s_ready), 1);
    chk("bp_lvl15", 32'(level), 15);
    for (int i = 1; i < 16; i++) begin
      pop();
      chk("bp_order", 32'(pix_data), 32'('h300 + i));
    end
    chk("bp_drain", 32'(level), 0);

    pop();
    chk("uf_pix", 32'(pix_data), 0);
    chk("uf_set", 32'(underflow), 1);
    tick();
    chk("uf_hold", 32'(underflow), 1);
    clr = 1'b1;
    pix_req = 1'b1;
    tick();
    clr = 1'b0;
    pix_req = 1'b0;
    chk("uf_setwins", 32'(underflow), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("uf_clr", 32'(underflow), 0);

    do_reset();
    ef = 0;
    fd = 0;
    beat(24'h500, 1'b1);
    ef += 32'(sof_err);
    beat(24'h501, 1'b0);
    ef += 32'(sof_err);
    beat(24'h502, 1'b1);
    chk("esof_err", 32'(sof_err), 1);
    ef += 32'(sof_err);
    for (int k = 0; k < 7; k++) begin
      beat(24'(32'h510 + k), 1'b0);
      ef += 32'(sof_err);
      fd += 32'(frame_done);
      chk("esof_done", 32'(frame_done), 32'(k == 6));
    end
    chk("esof_errcnt", 32'(ef), 1);
    chk("esof_donecnt", 32'(fd), 1);
    chk("esof_level", 32'(level), 10);

    do_reset();
    for (int i = 0; i < 5; i++) beat(24'(32'h600 + i), i == 0);
    chk("ar_level5", 32'(level), 5);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_level0", 32'(level), 0);
    chk("ar_ready0", 32'(s_ready), 0);
    tick();
    rst = 1'b1;
    pop();
    chk("ar_pix", 32'(pix_data), 0);
    chk("ar_uf", 32'(underflow), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pix_stream_in.md
# pix_stream_in

Upstream pixel ingress stage for the framebuffer. Accepts a frame-marked 24-bit RGB pixel stream over a valid/ready handshake and aligns it to start-of-frame. It buffers the pixels in a small FIFO and hands one pixel per write-enable pulse to the framebuffer write port. It runs entirely in the pixel clock domain, and its output drives the framebuffer data input directly.

## Interface
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- DEPTH, 16, FIFO entries; power of two, at least 4

- clk  input  1  pixel clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset (asserts immediately, release synchronous to clk externally)
- s_data  input  24  pixel {R[23:16], G[15:8], B[7:0]}
- s_valid  input  1  s_data/s_sof valid
- s_sof  input  1  beat is pixel 0 of a frame
- s_ready  output  1  beat accepted when s_valid && s_ready
- pix_req  input  1  framebuffer write enable; pops one pixel
- pix_data  output  24  pixel to framebuffer
- level  output  $clog2(DEPTH)+1  FIFO occupancy
- underflow  output  1  sticky; pop while empty
- sof_err  output  1  one-cycle pulse; s_sof accepted mid-frame
- frame_done  output  1  one-cycle pulse; last pixel of frame accepted
- clr  input  1  synchronous clear of underflow

## Operation
- State machine: WAIT_SOF, STREAM.
- WAIT_SOF behaviour:
  - Accepted beats with s_sof=0 are discarded, not written to the FIFO.
  - An accepted beat with s_sof=1 is written, sets pix_cnt=1 and moves to STREAM.
- STREAM behaviour:
  - Every accepted beat is written and increments pix_cnt.
  - On the beat that makes pix_cnt == WIDTH*HEIGHT: pulse frame_done, go to WAIT_SOF, set pix_cnt=0.
  - Accepted s_sof=1 in STREAM (early SOF): pulse sof_err, write the beat, set pix_cnt=1, stay in STREAM. The FIFO is not flushed.
- pix_cnt width: $clog2(WIDTH*HEIGHT+1). It never wraps; the frame end is always detected by compare.
- s_ready = !full in both states, derived from registered occupancy only, with no combinational path from pix_req.
- Pop: when pix_req=1 and the FIFO is non-empty, pix_data takes the head entry next cycle.
  - pix_req=1 with an empty FIFO: pix_data <= 24'h000000, underflow <= 1. A same-cycle push still lands; there is no bypass.
  - pix_req=0: pix_data holds its value.
- Simultaneous push and pop (not full, not empty): both occur and level is unchanged.
- underflow: clr=1 clears it. If clr and a new underflow event occur in the same cycle, the set wins.
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level = count register, range 0..DEPTH.

## Timing
- Reset values: pix_data=0, level=0, underflow=0, sof_err=0, frame_done=0, state=WAIT_SOF, pix_cnt=0.
- s_ready=0 while rst is low; s_ready=1 on the first cycle after release.
- Reset asserted mid-frame: all state is discarded immediately; the next frame needs a new s_sof.
- Pop latency: 1 cycle from pix_req to pix_data.
- Push-to-pop latency: 1 cycle. Data written at edge N can be popped by pix_req at edge N+1 and appears on pix_data after edge N+1.
- level updates on the edge after the push/pop.
- sof_err and frame_done are registered and assert the cycle after the causing beat.
- Throughput: 1 pixel/cycle in and out sustained.

## Configuration
- PIX_STREAM_IN_PATTERN_EN
- Defined: adds input port pattern_en (1 bit).
  - While pattern_en=1, each pix_req outputs 8-bar colour bars from an internal column counter col (0..WIDTH-1, wraps to 0).
  - Bar index = col*8/WIDTH. Bar order: white, yellow, cyan, green, magenta, red, blue, black, each using full-scale 8'hFF components.
  - While pattern_en=1: the FIFO is not popped, underflow is not set, and the input side keeps operating normally.
- Not defined: no pattern_en port, no column counter; behaviour as above only.

## Test plan
- Reset/align:
  - After rst release, send 3 beats with s_sof=0, then a beat with s_sof=1 and data 24'h112233.
  - Required: level stays 0 for the first 3 beats, then becomes 1. The next pix_req yields 24'h112233 one cycle later.
- Full frame with small params (WIDTH=4, HEIGHT=2):
  - Send SOF plus 7 beats with incrementing data, popping continuously.
  - Required: frame_done pulses once, the cycle after beat 8. State returns to WAIT_SOF, and a following non-SOF beat is discarded.
- Backpressure:
  - Push DEPTH beats with no pops.
  - Required: s_ready=0 and level=DEPTH, and a further s_valid beat is not accepted.
  - Then one pop: s_ready=1 the next cycle, and the data order is preserved.
- Underflow:
  - pix_req with an empty FIFO.
  - Required: pix_data=0 and underflow=1, held until clr=1. clr and an underflow in the same cycle leaves underflow=1.
- Early SOF:
  - s_sof=1 on the 3rd pixel of a frame.
  - Required: sof_err pulses once, and frame_done fires after WIDTH*HEIGHT-1 further beats.
- Async reset mid-stream:
  - Drop rst with level=5.
  - Required: level=0 and s_ready=0 immediately. After release, the next pop underflows.
